sume_calc: RTL and testbench

Parametrised keypad-driven two-operand decimal calculator, the successor of the fixed 3-digit adder in the keypad datapath. It accepts one 4-bit key code per strobe from the debounced keypad scanner. It assembles two decimal operands of up to `NDIGITS` digits, then adds or subtracts them on `=`. It presents the operands and a sign/magnitude result to the display driver.

---
 rtl/sume_calc.sv | 270 +++++++++++++++++++++++++++
 tb/tb_sume_calc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sume_calc.sv
// rtl/sume_calc.sv - keypad-driven two-operand decimal add/subtract calculator
// Optional sequential binary-to-BCD result conversion when SUME_CALC_BCD_EN is defined.
module sume_calc #(
   parameter int NDIGITS = 3,
   parameter int WORD_W  = 12
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     key_valid,
   input  logic [3:0]               key,
   output logic [WORD_W-1:0]        w1,
   output logic [WORD_W-1:0]        w2,
   output logic [WORD_W-1:0]        sum,
   output logic                     neg,
   output logic                     result_valid,
   output logic                     done,
`ifdef SUME_CALC_BCD_EN
   output logic                     busy,
   output logic [4*(NDIGITS+1)-1:0] bcd
`else
   output logic                     busy
`endif
);

   localparam int CNT_W = $clog2(NDIGITS + 1);
   localparam logic [3:0] K_ADD = 4'hA;
   localparam logic [3:0] K_SUB = 4'hB;
   localparam logic [3:0] K_EQ  = 4'hC;
   localparam logic [3:0] K_CLR = 4'hF;

   typedef enum logic [2:0] {
      ENTER_A,
      ENTER_B,
      CALC,
      SHOW
`ifdef SUME_CALC_BCD_EN
      , CONV
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [WORD_W-1:0]  a_q, a_d;
   logic [WORD_W-1:0]  b_q, b_d;
   logic [WORD_W-1:0]  sum_q, sum_d;
   logic               neg_q, neg_d;
   logic               rv_q, rv_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_q, op_d;

   logic               accept;
   logic               is_digit;
   logic               is_op;
   logic               room;
   logic [WORD_W-1:0]  digit_w;
   logic [WORD_W-1:0]  calc_res;
   logic               calc_neg;

`ifdef SUME_CALC_BCD_EN
   localparam int BCD_W = 4 * (NDIGITS + 1);
   localparam int BIT_W = $clog2(WORD_W + 1);

   logic [WORD_W-1:0]  sh_q, sh_d;
   logic [BCD_W-1:0]   acc_q, acc_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BCD_W-1:0]   adj;
   logic [BCD_W-1:0]   shifted;

   // Double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
   always_comb begin
      adj = acc_q;
      for (int i = 0; i < NDIGITS + 1; i++) begin
         if (adj[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
         end
      end
      shifted = {adj[BCD_W-2:0], sh_q[WORD_W-1]};
   end

   assign bcd  = bcd_q;
   assign busy = (state_q == CALC) || (state_q == CONV);
`else
   assign busy = (state_q == CALC);
`endif

   assign accept   = key_valid && !busy;
   assign is_digit = (key <= 4'd9);
   assign is_op    = (key == K_ADD) || (key == K_SUB);
   assign room     = (cnt_q < CNT_W'(NDIGITS));
   assign digit_w  = {{(WORD_W-4){1'b0}}, key};

   always_comb begin
      calc_neg = 1'b0;
      calc_res = a_q + b_q;
      if (op_q) begin
         if (a_q >= b_q) begin
            calc_res = a_q - b_q;
         end else begin
            calc_res = b_q - a_q;
            calc_neg = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      neg_d   = neg_q;
      rv_d    = rv_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      op_d    = op_q;
`ifdef SUME_CALC_BCD_EN
      sh_d    = sh_q;
      acc_d   = acc_q;
      bit_d   = bit_q;
      bcd_d   = bcd_q;
`endif
      case (state_q)
         ENTER_A: begin
            if (accept) begin
               if (is_digit) begin
                  if (room) begin
                     a_d   = a_q * WORD_W'(10) + digit_w;
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if (is_op) begin
                  op_d    = (key == K_SUB);
                  cnt_d   = '0;
                  state_d = ENTER_B;
               end
            end
         end
         ENTER_B: begin
            if (accept) begin
               if (is_digit) begin
                  if (room) begin
                     b_d   = b_q * WORD_W'(10) + digit_w;
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if (key == K_EQ) begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            sum_d = calc_res;
            neg_d = calc_neg;
`ifdef SUME_CALC_BCD_EN
            sh_d    = calc_res;
            acc_d   = '0;
            bit_d   = '0;
            state_d = CONV;
`else
            rv_d    = 1'b1;
            done_d  = 1'b1;
            state_d = SHOW;
`endif
         end
`ifdef SUME_CALC_BCD_EN
         CONV: begin
            acc_d = shifted;
            sh_d  = {sh_q[WORD_W-2:0], 1'b0};
            bit_d = bit_q + 1'b1;
            if (bit_q == BIT_W'(WORD_W - 1)) begin
               bcd_d   = shifted;
               rv_d    = 1'b1;
               done_d  = 1'b1;
               state_d = SHOW;
            end
         end
`endif
         SHOW: begin
            if (accept) begin
               if (is_digit) begin
                  a_d     = digit_w;
                  b_d     = '0;
                  sum_d   = '0;
                  neg_d   = 1'b0;
                  rv_d    = 1'b0;
                  cnt_d   = CNT_W'(1);
                  op_d    = 1'b0;
`ifdef SUME_CALC_BCD_EN
                  bcd_d   = '0;
`endif
                  state_d = ENTER_A;
               end else if (is_op) begin
                  // A negative result cannot be carried forward as an unsigned operand.
                  a_d     = neg_q ? '0 : sum_q;
                  b_d     = '0;
                  cnt_d   = '0;
                  op_d    = (key == K_SUB);
                  rv_d    = 1'b0;
                  state_d = ENTER_B;
               end
            end
         end
         default: state_d = ENTER_A;
      endcase

      if (accept && (key == K_CLR)) begin
         state_d = ENTER_A;
         a_d     = '0;
         b_d     = '0;
         sum_d   = '0;
         neg_d   = 1'b0;
         rv_d    = 1'b0;
         done_d  = 1'b0;
         cnt_d   = '0;
         op_d    = 1'b0;
`ifdef SUME_CALC_BCD_EN
         sh_d    = '0;
         acc_d   = '0;
         bit_d   = '0;
         bcd_d   = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= ENTER_A;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         neg_q   <= 1'b0;
         rv_q    <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         op_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         neg_q   <= neg_d;
         rv_q    <= rv_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

`ifdef SUME_CALC_BCD_EN
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         sh_q  <= '0;
         acc_q <= '0;
         bit_q <= '0;
         bcd_q <= '0;
      end else begin
         sh_q  <= sh_d;
         acc_q <= acc_d;
         bit_q <= bit_d;
         bcd_q <= bcd_d;
      end
   end
`endif

   assign w1           = a_q;
   assign w2           = b_q;
   assign sum          = sum_q;
   assign neg          = neg_q;
   assign result_valid = rv_q;
   assign done         = done_q;

endmodule

// File: tb/tb_sume_calc.sv
// tb/tb_sume_calc.sv - randomized scoreboard bench for sume_calc
`timescale 1ns/1ps
module tb_sume_calc;

   localparam int ND = 3;
   localparam int WW = 12;
   localparam int BW = 4 * (ND + 1);

   logic          clk = 1'b0;
   logic          n_reset = 1'b0;
   logic          key_valid = 1'b0;
   logic [3:0]    key = 4'h0;
   logic [WW-1:0] w1, w2, sum;
   logic          neg, result_valid, done, busy;
`ifdef SUME_CALC_BCD_EN
   logic [BW-1:0] bcd;
`endif

   always #18 clk = ~clk;

   sume_calc #(.NDIGITS(ND), .WORD_W(WW)) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .key_valid    (key_valid),
      .key          (key),
      .w1           (w1),
      .w2           (w2),
      .sum          (sum),
      .neg          (neg),
      .result_valid (result_valid),
      .done         (done),
      .busy         (busy)
`ifdef SUME_CALC_BCD_EN
      , .bcd        (bcd)
`endif
   );

   typedef struct {
      int s;
      int n;
      int a;
      int b;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: calculator behaviour expressed as plain integer arithmetic.
   int m_phase, m_a, m_b, m_n, m_sum, m_neg, m_op, m_rv;
   bit m_pushed;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

`ifdef SUME_CALC_BCD_EN
   function automatic logic [BW-1:0] to_bcd(input int v);
      logic [BW-1:0] r;
      r = '0;
      for (int i = 0; i < ND + 1; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction
`endif

   task automatic m_clear();
      m_phase = 0; m_a = 0; m_b = 0; m_n = 0;
      m_sum = 0; m_neg = 0; m_op = 0; m_rv = 0;
   endtask

   task automatic model_key(input int k);
      exp_t e;
      m_pushed = 1'b0;
      if (k == 15) begin
         m_clear();
      end else begin
         case (m_phase)
            0: begin
               if (k < 10) begin
                  if (m_n < ND) begin m_a = m_a * 10 + k; m_n++; end
               end else if (k == 10 || k == 11) begin
                  m_op = (k == 11); m_n = 0; m_phase = 1;
               end
            end
            1: begin
               if (k < 10) begin
                  if (m_n < ND) begin m_b = m_b * 10 + k; m_n++; end
               end else if (k == 12) begin
                  if (m_op == 0) begin m_sum = m_a + m_b; m_neg = 0; end
                  else if (m_a >= m_b) begin m_sum = m_a - m_b; m_neg = 0; end
                  else begin m_sum = m_b - m_a; m_neg = 1; end
                  m_rv = 1; m_phase = 2;
                  e.s = m_sum; e.n = m_neg; e.a = m_a; e.b = m_b;
                  sb_q.push_back(e);
                  m_pushed = 1'b1;
               end
            end
            default: begin
               if (k < 10) begin
                  m_a = k; m_n = 1; m_b = 0; m_sum = 0; m_neg = 0; m_rv = 0; m_phase = 0;
               end else if (k == 10 || k == 11) begin
                  m_a = m_neg ? 0 : m_sum;
                  m_b = 0; m_n = 0; m_op = (k == 11); m_rv = 0; m_phase = 1;
               end
            end
         endcase
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".w1"}, w1, m_a);
      chk({tag, ".w2"}, w2, m_b);
      chk({tag, ".sum"}, sum, m_sum);
      chk({tag, ".neg"}, neg, m_neg);
      chk({tag, ".rv"}, result_valid, m_rv);
   endtask

   // Called just after a rising edge: present one key for exactly one sampling edge.
   task automatic drive(input int k);
      key_valid = 1'b1;
      key = 4'(k);
      model_key(k);
      @(posedge clk); #1;
   endtask

   task automatic idle_check(input string tag);
      int t;
      key_valid = 1'b0;
      t = 0;
      while (busy && t < WW + 8) begin
         @(negedge clk);
         t++;
      end
      if (busy) begin
         errors++; checks++;
         $display("FAIL %s.timeout: busy still %0d expected 0", tag, busy);
      end
      check_state(tag);
      @(posedge clk); #1;
   endtask

   task automatic send_seq(input string tag, input int ks[$]);
      foreach (ks[i]) begin
         drive(ks[i]);
         idle_check(tag);
      end
   endtask

   always @(negedge clk) begin
      if (n_reset && done) begin
         if (sb_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL done: got unexpected pulse expected none");
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("mon.sum", sum, e.s);
            chk("mon.neg", neg, e.n);
            chk("mon.w1", w1, e.a);
            chk("mon.w2", w2, e.b);
            chk("mon.rv", result_valid, 1);
`ifdef SUME_CALC_BCD_EN
            chk("mon.bcd", bcd, to_bcd(e.s));
`endif
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int r, k;
      m_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("rst.w1", w1, 0);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      check_state("rst");
      n_reset = 1'b1;
      @(posedge clk); #1;

      send_seq("basic", '{1, 2, 3, 10, 4, 5, 6, 12});
      chk("basic.sum579", sum, 579);
      send_seq("chain", '{10, 1, 12});
      chk("chain.sum580", sum, 580);
      chk("chain.w1", w1, 579);
      send_seq("restart", '{7});
      chk("restart.w1", w1, 7);
      chk("restart.rv", result_valid, 0);

      send_seq("negsub", '{15, 1, 2, 11, 3, 4, 5, 12});
      chk("negsub.sum", sum, 333);
      chk("negsub.neg", neg, 1);

      send_seq("limit", '{15, 9, 9, 9, 9, 10, 9, 9, 9, 12});
      chk("limit.w1", w1, 999);
      chk("limit.sum", sum, 1998);

      send_seq("clear", '{15, 4, 5, 15});
      chk("clear.w1", w1, 0);
      send_seq("ignored", '{12, 13, 14, 5, 13, 11, 10, 14, 2, 12});
      chk("twoop.sum", sum, 3);

      // Back-to-back strobes, then a clear strobed in the CALC cycle must be dropped.
      drive(15); drive(6); drive(10); drive(2);
      idle_check("b2b");
      drive(12);
      key = 4'hF;
      @(posedge clk); #1;
      idle_check("drop");
      chk("drop.sum", sum, 8);

      // Asynchronous reset aborting a computation.
      send_seq("abort", '{15, 4, 11, 5});
      drive(12);
      key_valid = 1'b0;
`ifdef SUME_CALC_BCD_EN
      repeat (3) @(posedge clk);
`endif
      #5;
      n_reset = 1'b0;
      #2;
      chk("abort.busy", busy, 0);
      chk("abort.done", done, 0);
      sb_q.delete();
      m_clear();
      check_state("abort");
      @(negedge clk);
      n_reset = 1'b1;
      @(posedge clk); #1;
      repeat (WW + 4) @(posedge clk);
      #1;
      check_state("postabort");

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 55)      k = $urandom_range(0, 9);
         else if (r < 68) k = $urandom_range(10, 11);
         else if (r < 84) k = 12;
         else if (r < 90) k = $urandom_range(13, 14);
         else if (r < 94) k = 15;
         else             k = $urandom_range(0, 9);
         drive(k);
         if (m_pushed || $urandom_range(0, 2) == 0) idle_check("rand");
      end
      idle_check("final");
      repeat (WW + 4) @(posedge clk);
      #1;
      chk("sb.empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
